// File: rtl/les_dec_top_if.sv
// Request/response bundle between a requester and the LES decryption core.
// The requester drives cipher_in/start; the core returns busy/done/plaintext_out.
interface les_dec_if;
   logic [31:0] cipher_in;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] plaintext_out;

   modport master (output cipher_in, start, input busy, done, plaintext_out);
   modport slave  (input cipher_in, start, output busy, done, plaintext_out);
endinterface

// File: rtl/les_dec_top.sv
// LES toy-cipher decryption core: four inverse rounds, one per clock, over one state register.
// Optional macro LES_DEC_AMPLIFY_EN adds kept SB_LUT4 buffer chains on state bits 0/8/16/24.
module les_dec_top #(
   parameter int unsigned ROUNDS  = 4,
   parameter logic [31:0] XOR_KEY = 32'hDEADC0DE
) (
   input logic  clk,
   input logic  clr,
   les_dec_if.slave bus
);

   localparam logic [1:0] LAST_CTR = 2'(ROUNDS - 1);

   // AES forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return 8'(SBOX_TABLE >> (11'd2040 - {b, 3'b000}));
   endfunction

   function automatic logic [31:0] inv_round(input logic [31:0] y);
      logic [31:0] r;
      r = {y[7:0], y[31:8]};
      return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])} ^ XOR_KEY;
   endfunction

`ifdef LES_DEC_AMPLIFY_EN
   (* keep *) logic [31:0] state_q;
`else
   logic [31:0] state_q;
`endif
   logic [31:0] state_d;
   logic [1:0]  ctr_q;
   logic [1:0]  ctr_d;
   logic        done_q;
   logic        done_d;
   logic [31:0] round_in_s;

   // Next-state logic: accept in idle, otherwise run the remaining rounds.
   always_comb begin
      ctr_d      = ctr_q;
      state_d    = state_q;
      done_d     = 1'b0;
      round_in_s = (ctr_q != 2'd0) ? state_q : bus.cipher_in;
      if (ctr_q == 2'd0) begin
         if (bus.start) begin
            state_d = inv_round(round_in_s);
            ctr_d   = 2'd1;
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = inv_round(round_in_s);
         if (ctr_q == LAST_CTR) begin
            ctr_d  = 2'd0;
            done_d = 1'b1;
         end else begin
            ctr_d  = ctr_q + 2'd1;
         end
      end
   end

   // State registers; clr aborts any request in flight.
   always_ff @(posedge clk) begin
      if (clr) begin
         ctr_q   <= 2'd0;
         state_q <= 32'h0000_0000;
         done_q  <= 1'b0;
      end else begin
         ctr_q   <= ctr_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy          = ~clr & ((ctr_q != 2'd0) | bus.start);
   assign bus.done          = done_q;
   assign bus.plaintext_out = state_q;

`ifdef LES_DEC_AMPLIFY_EN
   // Buffer chains exist only to load the selected state bits for power analysis.
   for (genvar c = 0; c < 4; c++) begin : g_chain
      (* keep *) logic [64:0] tap_s;
      assign tap_s[0] = state_q[8*c];
      for (genvar i = 0; i < 64; i++) begin : g_buf
         (* keep *) SB_LUT4 #(.LUT_INIT(16'h0002)) u_lut (
            .O (tap_s[i+1]),
            .I0(tap_s[i]),
            .I1(1'b0),
            .I2(1'b0),
            .I3(1'b0)
         );
      end
   end
`endif

endmodule

// File: tb/tb_les_dec_top.sv
// Self-checking bench for les_dec_top: spec-level timing model plus directed scenarios.
// The S-box is rebuilt from GF(2^8) inversion and the affine map, independent of the RTL table.
module tb_les_dec_top;
   localparam logic [31:0] KEY = 32'hDEADC0DE;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   les_dec_if bus ();
   les_dec_top u_dut (.clk(clk), .clr(clr), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;
   int ndone  = 0;

   logic [7:0] sbox_m  [256];
   logic [7:0] isbox_m [256];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         sbox_m[a]  = s;
         isbox_m[s] = 8'(a);
      end
   endtask

   function automatic logic [31:0] m_round(input logic [31:0] y);
      logic [31:0] t, o;
      t = (y >> 8) | (y << 24);
      for (int k = 0; k < 4; k++) o[8*k +: 8] = sbox_m[t[8*k +: 8]];
      return o ^ KEY;
   endfunction

   function automatic logic [31:0] m_dec(input logic [31:0] c);
      logic [31:0] y = c;
      for (int r = 0; r < 4; r++) y = m_round(y);
      return y;
   endfunction

   function automatic logic [31:0] m_enc(input logic [31:0] p);
      logic [31:0] t = p;
      for (int r = 0; r < 4; r++) begin
         t = t ^ KEY;
         for (int k = 0; k < 4; k++) t[8*k +: 8] = isbox_m[t[8*k +: 8]];
         t = (t << 8) | (t >> 24);
      end
      return t;
   endfunction

   // Timing model: cycle index of last accept, cycle in which done is due, expected result.
   int          cyc = 0;
   int          acc = -100;
   int          fin = -100;
   logic [31:0] m_res, m_out;
   bit          out_known = 1'b0;
   bit          armed = 1'b0;

   always @(posedge clk) begin
      if (clr) begin
         acc = -100; fin = -100; m_out = 32'h0; out_known = 1'b1; armed = 1'b1;
      end else begin
         if (cyc - acc == 3) begin
            m_out = m_res; out_known = 1'b1; fin = cyc + 1;
         end
         if (cyc - acc >= 4 && bus.start) begin
            acc = cyc; m_res = m_dec(bus.cipher_in); out_known = 1'b0;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      #2;
      if (armed) begin
         chk("busy", 32'(bus.busy), 32'(!clr && ((cyc - acc) < 4 || bus.start)));
         chk("done", 32'(bus.done), 32'(cyc == fin));
         if (out_known) chk("plaintext", bus.plaintext_out, m_out);
      end
   end

   always @(negedge clk) if (bus.done === 1'b1) ndone++;

   task automatic send(input logic [31:0] x, input logic [31:0] exp, input string name);
      @(negedge clk); bus.start = 1'b1; bus.cipher_in = x;
      @(negedge clk); bus.start = 1'b0; bus.cipher_in = $urandom;
      repeat (3) @(negedge clk);
      #3;
      chk({name, "_done"}, 32'(bus.done), 32'h1);
      chk({name, "_out"}, bus.plaintext_out, exp);
   endtask

   logic [31:0] rt_words [4] = '{32'h00000000, 32'hDEADC0DE, 32'hFFFFFFFF, 32'h12345678};
   logic [31:0] b2b [3]      = '{32'h0BADF00D, 32'hCAFEBABE, 32'h55AA33CC};
   logic [31:0] va, vb;

   initial begin
      build_tables();
      chk("sbox_00", 32'(sbox_m[0]), 32'h63);
      chk("sbox_53", 32'(sbox_m[8'h53]), 32'hED);
      chk("sbox_ff", 32'(sbox_m[8'hFF]), 32'h16);
      chk("r1_zero", m_round(32'h0), 32'hBDCEA3BD);

      // reset with start held high
      clr = 1'b1; bus.start = 1'b1; bus.cipher_in = 32'h12345678;
      repeat (2) @(negedge clk);
      clr = 1'b0; bus.start = 1'b0;
      #3;
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_out", bus.plaintext_out, 32'h0);

      // encrypt-then-decrypt round trip
      foreach (rt_words[i]) send(m_enc(rt_words[i]), rt_words[i], "roundtrip");

      // start while busy at ctr=2 is ignored
      ndone = 0; va = 32'hA5A5_0001; vb = 32'h5A5A_0002;
      @(negedge clk); bus.start = 1'b1; bus.cipher_in = va;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); bus.start = 1'b1; bus.cipher_in = vb;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); #3;
      chk("ignore_done", 32'(bus.done), 32'h1);
      chk("ignore_out", bus.plaintext_out, m_dec(va));
      repeat (6) @(negedge clk);
      chk("ignore_pulses", 32'(ndone), 32'h1);

      // back-to-back with start held
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); bus.start = 1'b1; bus.cipher_in = b2b[i/4];
         #3;
         if (i == 4 || i == 8) begin
            chk("b2b_done", 32'(bus.done), 32'h1);
            chk("b2b_out", bus.plaintext_out, m_dec(b2b[i/4 - 1]));
         end
      end
      @(negedge clk); bus.start = 1'b0; #3;
      chk("b2b_last", bus.plaintext_out, m_dec(b2b[2]));

      // abort with clr at ctr=3
      @(negedge clk); bus.start = 1'b1; bus.cipher_in = 32'h0F1E2D3C;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0; #3;
      chk("abort_done", 32'(bus.done), 32'h0);
      chk("abort_out", bus.plaintext_out, 32'h0);
      send(32'h89ABCDEF, m_dec(32'h89ABCDEF), "after_abort");

      // random words, start held, cipher changes every cycle
      bus.start = 1'b1;
      repeat (4000) begin
         @(negedge clk); bus.cipher_in = $urandom;
      end
      @(negedge clk); bus.start = 1'b0;
      repeat (6) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
